if_ctrl: RTL and testbench
==========================

Name: if_ctrl

Overview:
- Pipeline front-end controller that sequences the instruction-fetch stage.
- Turns hazard and redirect events from ID/EX/MEM into registered control for IF, ID and EX:
  - IF: is_stall, is_flush, branch_target
  - ID: id_stall, id_flush
  - EX: ex_bubble
- Also provides halt/resume for debug, plus saturating stall/flush performance counters and a stall watchdog.

Parameters:
- XLEN, 32, width of branch_target.
- FLUSH_CYCLES, 2, number of cycles id_flush is held after a redirect (1..7).
- STALL_MAX, 15, consecutive MEM-stall cycles before watchdog_err sets.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- ex_branch_target  in  XLEN  redirect address, valid with ex_branch_taken.
- id_load_use  in  1  ID detected a load-use hazard.
- mem_busy  in  1  data memory is not ready; the pipeline must freeze.
- halt_req  in  1  debug halt request (level).
- resume  in  1  debug resume pulse.
- is_flush  out  1  IF loads branch_target into PC (1-cycle pulse).
- is_stall  out  1  IF holds PC/instr.
- branch_target  out  XLEN  registered redirect address.
- id_stall  out  1  IF/ID register hold.
- id_flush  out  1  IF/ID register clear.
- ex_bubble  out  1  inject NOP into ID/EX.
- halted  out  1  controller is in HALT.
- stall_cnt  out  CNT_W  cycles with is_stall=1, saturating.
- flush_cnt  out  CNT_W  redirect events, saturating.
- watchdog_err  out  1  sticky; MEM stall exceeded STALL_MAX.

Behaviour:
- Reset (reset=0, async): state=RUN; all outputs 0; branch_target=0; internal counters 0.
- All outputs are registered. The response appears the cycle after the event is sampled.
- States: RUN, LU_STALL, MEM_STALL, REDIRECT, HALT.
- Priority in RUN and REDIRECT: ex_branch_taken > mem_busy > id_load_use > halt_req.
- Redirect (ex_branch_taken sampled):
  - Capture ex_branch_target into branch_target; go to REDIRECT.
  - is_flush=1 for exactly 1 cycle.
  - id_flush=1 for FLUSH_CYCLES cycles; ex_bubble=1 on the first of those cycles.
  - flush_cnt += 1.
  - Return to RUN after FLUSH_CYCLES cycles.
  - A new branch during REDIRECT recaptures the target, re-pulses is_flush, restarts the flush count and increments flush_cnt again.
- Load-use (in RUN only):
  - LU_STALL lasts exactly 1 cycle with is_stall=id_stall=ex_bubble=1, then back to RUN.
  - Load-use coincident with a branch is dropped; the branch wins.
- MEM stall:
  - While mem_busy=1: state MEM_STALL, is_stall=id_stall=1, ex_bubble=0 (whole pipe frozen).
  - Exit to RUN the cycle after mem_busy falls.
  - A consecutive-cycle counter runs; on reaching STALL_MAX, watchdog_err=1. It is sticky until reset, and stalling continues.
- ex_branch_taken and id_load_use are ignored in LU_STALL, MEM_STALL and HALT. Upstream holds them frozen, and they are re-sampled after return to RUN.
- Halt:
  - halt_req=1 in RUN with no other event: enter HALT. is_stall=id_stall=halted=1.
  - A resume pulse returns to RUN on the next cycle; halted=0 that cycle.
  - If halt_req is still high after resume, HALT is re-entered one cycle later.
  - resume outside HALT is ignored.
- stall_cnt increments on every cycle is_stall=1. Both counters saturate at 2^CNT_W-1 with no wrap.
- Reset asserted mid-redirect or mid-stall: immediate return to reset values; no pending flush survives.

Test Plan:
- Release reset at 12 ns, idle 10 cycles -> all controls 0, stall_cnt=0, flush_cnt=0.
- ex_branch_taken=1 with target 32'h00000020 for 1 cycle -> next cycle branch_target=0x20 and is_flush=1 for 1 cycle; id_flush=1 for 2 cycles; flush_cnt=1.
- id_load_use=1 and ex_branch_taken=1 (target 0x40) in the same cycle -> redirect to 0x40 only; no LU_STALL; stall_cnt unchanged. Then id_load_use alone -> exactly 1 cycle with is_stall=ex_bubble=1; stall_cnt=1.
- mem_busy high 20 cycles (STALL_MAX=15) -> is_stall high 20 cycles; watchdog_err sets on the 15th stall cycle and stays 1 after mem_busy drops.
- halt_req=1 for 5 cycles, then resume pulse with halt_req=0 -> halted=1 throughout, RUN one cycle after resume. Then assert reset during a FLUSH_CYCLES=2 redirect -> all outputs 0 immediately.
- Force stall_cnt near saturation (CNT_W=4, 20 stall cycles) -> stall_cnt holds at 15.

Source files
------------

// File: rtl/if_ctrl.sv
// if_ctrl: IF-stage sequencer turning hazard/redirect events into registered IF/ID/EX control.
module if_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_MAX    = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_branch_taken,
    input  logic [XLEN-1:0]  ex_branch_target,
    input  logic             id_load_use,
    input  logic             mem_busy,
    input  logic             halt_req,
    input  logic             resume,
    output logic             is_flush,
    output logic             is_stall,
    output logic [XLEN-1:0]  branch_target,
    output logic             id_stall,
    output logic             id_flush,
    output logic             ex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             watchdog_err
);
    localparam int WW = $clog2(STALL_MAX + 1);
    typedef enum logic [2:0] {RUN, LU_STALL, MEM_STALL, REDIRECT, HALT} state_t;
    state_t state, nxt;
    logic [2:0] fl_cnt, nxt_fl;
    logic [WW-1:0] wd_cnt, nxt_wd;
    logic redir, nxt_stall;
    always_comb begin
        nxt    = state;
        nxt_fl = fl_cnt;
        redir  = 1'b0;
        case (state)
            RUN, REDIRECT: begin
                if (ex_branch_taken) begin
                    nxt    = REDIRECT;
                    nxt_fl = 3'(FLUSH_CYCLES - 1);
                    redir  = 1'b1;
                end else if (mem_busy) nxt = MEM_STALL;
                else if (state == REDIRECT) begin
                    // fl_cnt holds the flush cycles still owed after this one
                    if (fl_cnt != 3'd0) nxt_fl = fl_cnt - 3'd1;
                    else nxt = RUN;
                end else if (id_load_use) nxt = LU_STALL;
                else if (halt_req) nxt = HALT;
            end
            LU_STALL:  nxt = RUN;
            MEM_STALL: nxt = mem_busy ? MEM_STALL : RUN;
            HALT:      nxt = resume ? RUN : HALT;
            default:   nxt = RUN;
        endcase
        nxt_stall = (nxt == LU_STALL) || (nxt == MEM_STALL) || (nxt == HALT);
        nxt_wd    = (nxt != MEM_STALL) ? '0 :
                    (wd_cnt == WW'(STALL_MAX)) ? wd_cnt : wd_cnt + 1'b1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            fl_cnt        <= '0;
            wd_cnt        <= '0;
            is_flush      <= 1'b0;
            is_stall      <= 1'b0;
            id_stall      <= 1'b0;
            id_flush      <= 1'b0;
            ex_bubble     <= 1'b0;
            halted        <= 1'b0;
            branch_target <= '0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
            watchdog_err  <= 1'b0;
        end else begin
            state         <= nxt;
            fl_cnt        <= nxt_fl;
            wd_cnt        <= nxt_wd;
            is_flush      <= redir;
            is_stall      <= nxt_stall;
            id_stall      <= nxt_stall;
            id_flush      <= nxt == REDIRECT;
            ex_bubble     <= redir || nxt == LU_STALL;
            halted        <= nxt == HALT;
            branch_target <= redir ? ex_branch_target : branch_target;
            stall_cnt     <= stall_cnt + CNT_W'(nxt_stall && !(&stall_cnt));
            flush_cnt     <= flush_cnt + CNT_W'(redir && !(&flush_cnt));
            watchdog_err  <= watchdog_err || nxt_wd == WW'(STALL_MAX);
        end
    end
endmodule

// File: tb/tb_if_ctrl.sv
// tb_if_ctrl: directed vectors with hand-computed expectations for if_ctrl (CNT_W=4).
module tb_if_ctrl;
    logic clk = 1'b0, reset = 1'b0;
    logic ex_branch_taken = 1'b0, id_load_use = 1'b0, mem_busy = 1'b0;
    logic halt_req = 1'b0, resume = 1'b0;
    logic [31:0] ex_branch_target = '0, branch_target;
    logic is_flush, is_stall, id_stall, id_flush, ex_bubble, halted, watchdog_err;
    logic [3:0] stall_cnt, flush_cnt;
    int n_cmp = 0, n_err = 0;

    if_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .STALL_MAX(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target), .id_load_use(id_load_use),
        .mem_busy(mem_busy), .halt_req(halt_req), .resume(resume),
        .is_flush(is_flush), .is_stall(is_stall), .branch_target(branch_target),
        .id_stall(id_stall), .id_flush(id_flush), .ex_bubble(ex_bubble),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .watchdog_err(watchdog_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // packed control view: {is_flush,is_stall,id_stall,id_flush,ex_bubble,halted}
    function automatic logic [31:0] ctl;
        return {26'd0, is_flush, is_stall, id_stall, id_flush, ex_bubble, halted};
    endfunction

    initial begin
        #2;
        chk("rst_ctl", ctl(), 0);
        chk("rst_tgt", branch_target, 0);
        #10 reset = 1'b1;
        repeat (10) cyc();
        chk("idle_ctl", ctl(), 0);
        chk("idle_cnts", {stall_cnt, flush_cnt, 3'd0, watchdog_err}, 0);

        ex_branch_taken = 1'b1; ex_branch_target = 32'h20;
        cyc();
        ex_branch_taken = 1'b0;
        chk("br1_ctl", ctl(), 32'b100110);
        chk("br1_tgt", branch_target, 32'h20);
        chk("br1_fcnt", flush_cnt, 1);
        cyc();
        chk("br2_ctl", ctl(), 32'b000100);
        cyc();
        chk("br3_ctl", ctl(), 0);

        ex_branch_taken = 1'b1; id_load_use = 1'b1; ex_branch_target = 32'h40;
        cyc();
        ex_branch_taken = 1'b0; id_load_use = 1'b0;
        chk("co_ctl", ctl(), 32'b100110);
        chk("co_tgt", branch_target, 32'h40);
        chk("co_fcnt", flush_cnt, 2);
        chk("co_scnt", stall_cnt, 0);
        cyc(); cyc();
        chk("co_end", ctl(), 0);

        id_load_use = 1'b1;
        cyc();
        id_load_use = 1'b0;
        chk("lu_ctl", ctl(), 32'b011010);
        chk("lu_scnt", stall_cnt, 1);
        cyc();
        chk("lu_end", ctl(), 0);
        chk("lu_scnt2", stall_cnt, 1);

        mem_busy = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk($sformatf("mem_ctl%0d", i), ctl(), 32'b011000);
            if (i == 13) chk("mem_scnt13", stall_cnt, 14);
            if (i == 14) chk("wd_14", watchdog_err, 0);
            if (i == 15) chk("wd_15", watchdog_err, 1);
        end
        mem_busy = 1'b0;
        chk("mem_sat", stall_cnt, 15);
        cyc();
        chk("mem_end", ctl(), 0);
        chk("wd_sticky", watchdog_err, 1);
        chk("sat_hold", stall_cnt, 15);

        halt_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk($sformatf("halt%0d", i), ctl(), 32'b011001);
        end
        halt_req = 1'b0; resume = 1'b1;
        cyc();
        resume = 1'b0;
        chk("resume", ctl(), 0);
        cyc();
        chk("run_after", ctl(), 0);

        ex_branch_taken = 1'b1; ex_branch_target = 32'h10;
        cyc();
        ex_branch_target = 32'h14;
        cyc();
        ex_branch_taken = 1'b0;
        chk("rebr_ctl", ctl(), 32'b100110);
        chk("rebr_tgt", branch_target, 32'h14);
        chk("rebr_fcnt", flush_cnt, 4);
        cyc();
        chk("rebr2", ctl(), 32'b000100);
        cyc();
        chk("rebr3", ctl(), 0);

        ex_branch_taken = 1'b1; ex_branch_target = 32'h80;
        cyc();
        ex_branch_taken = 1'b0;
        chk("pre_rst", is_flush, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_ctl", ctl(), 0);
        chk("arst_tgt", branch_target, 0);
        chk("arst_cnts", {stall_cnt, flush_cnt, 3'd0, watchdog_err}, 0);
        #2 reset = 1'b1;
        cyc();
        chk("post_rst", ctl(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
